// File: rtl/reg_bus_pkg.sv
// Shared types and defaults for the host register bus controller.
package reg_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_WAIT,
        ST_RESP
    } state_e;

    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_DATA_W   = 1;
    localparam int DEF_TIMEOUT  = 16;

    function automatic int rdata_off(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/reg_bus_timeout.sv
// Read-wait watchdog: loads TIMEOUT-1 on entry, counts down while enabled,
// flags expiry when the terminal count is reached.
module reg_bus_timeout
    import reg_bus_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(TIMEOUT - 1);
        end else if (en && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/reg_bus_ctrl.sv
// Host-side register access controller: one request in flight, one response each.
// Define REG_BUS_TIMEOUT_EN to error out reads whose register never answers.
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   ST_IDLE      | req_ready high, waiting for a host request
//   ST_WRITE     | one-cycle write strobe to the addressed register
//   ST_READ_WAIT | read enable held until the register reports ready
//   ST_RESP      | response presented until the host takes it
module reg_bus_ctrl
    import reg_bus_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = 3,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [DATA_W-1:0]          resp_rdata,
    output logic                       resp_err,
    output logic [NUM_REGS-1:0]        reg_wen,
    output logic [NUM_REGS-1:0]        reg_ren,
    output logic [DATA_W-1:0]          reg_wdata,
    input  logic [NUM_REGS*DATA_W-1:0] reg_rdata,
    input  logic [NUM_REGS-1:0]        reg_ready
);

    localparam logic [ADDR_W:0]     NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [NUM_REGS-1:0] SEL_LSB    = NUM_REGS'(1);

    state_e              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;
    logic [NUM_REGS-1:0] reg_wen_q, reg_wen_d;
    logic [NUM_REGS-1:0] reg_ren_q, reg_ren_d;
    logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                first_q, first_d;

    logic [DATA_W-1:0]   sel_rdata;
    logic                sel_ready;
    logic                tmo_load;
    logic                tmo_expired;

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                sel_rdata = reg_rdata[rdata_off(i, DATA_W) +: DATA_W];
                sel_ready = reg_ready[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        reg_wen_d    = '0;
        reg_ren_d    = reg_ren_q;
        reg_wdata_d  = reg_wdata_q;
        addr_d       = addr_q;
        first_d      = 1'b0;
        tmo_load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_ready_q && req_valid) begin
                    addr_d      = req_addr;
                    reg_wdata_d = req_wdata;
                    if ({1'b0, req_addr} >= NUM_REGS_W) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b1;
                    end else if (req_write) begin
                        state_d   = ST_WRITE;
                        reg_wen_d = SEL_LSB << req_addr;
                    end else begin
                        state_d   = ST_READ_WAIT;
                        reg_ren_d = SEL_LSB << req_addr;
                        first_d   = 1'b1;
                        tmo_load  = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
            end
            ST_READ_WAIT: begin
                // Ready is registered in the register block, so the first cycle may be stale.
                if (!first_q && sel_ready) begin
                    state_d      = ST_RESP;
                    reg_ren_d    = '0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = sel_rdata;
                    resp_err_d   = 1'b0;
                end else if (tmo_expired) begin
                    state_d      = ST_RESP;
                    reg_ren_d    = '0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

`ifdef REG_BUS_TIMEOUT_EN
    reg_bus_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmo_load),
        .en     (state_q == ST_READ_WAIT),
        .expired(tmo_expired)
    );
`else
    logic unused_tmo;
    assign tmo_expired = 1'b0;
    assign unused_tmo  = tmo_load ^ (TIMEOUT > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            reg_wen_q    <= '0;
            reg_ren_q    <= '0;
            reg_wdata_q  <= '0;
            addr_q       <= '0;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            reg_wen_q    <= reg_wen_d;
            reg_ren_q    <= reg_ren_d;
            reg_wdata_q  <= reg_wdata_d;
            addr_q       <= addr_d;
            first_q      <= first_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign reg_wen    = reg_wen_q;
    assign reg_ren    = reg_ren_q;
    assign reg_wdata  = reg_wdata_q;

endmodule

// File: tb/tb_reg_bus_ctrl.sv
// Bench for reg_bus_ctrl: attached register models with programmable read latency,
// expectations derived from the access rules (latency, data, error) per request.
module tb_reg_bus_ctrl;

    localparam int NREG = 8;
    localparam int DW   = 4;
    localparam int AW   = 4;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic resp_valid, resp_ready, resp_err;
    logic [DW-1:0] resp_rdata;
    logic [NREG-1:0] reg_wen, reg_ren, reg_ready;
    logic [DW-1:0] reg_wdata;
    logic [NREG*DW-1:0] reg_rdata;

    int total = 0;
    int bad   = 0;

    int              lat       [NREG];
    logic [NREG-1:0] stuck_vec = '0;
    logic [DW-1:0]   exp_mem   [NREG];
    logic [DW-1:0]   regs_mem  [NREG] = '{default: '0};
    int              ren_cnt   [NREG];
    logic [NREG-1:0] mdl_ready;
    logic [NREG-1:0] noise     = '0;

    always #5 clk = ~clk;

    reg_bus_ctrl #(
        .NUM_REGS(NREG),
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .reg_wen   (reg_wen),
        .reg_ren   (reg_ren),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_ready (reg_ready)
    );

    // Register models: store on wen, raise registered ready lat cycles into ren.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                ren_cnt[i]   <= 0;
                mdl_ready[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (reg_wen[i]) regs_mem[i] <= reg_wdata;
                if (reg_ren[i]) begin
                    ren_cnt[i]   <= ren_cnt[i] + 1;
                    mdl_ready[i] <= (ren_cnt[i] + 1 >= lat[i]);
                end else begin
                    ren_cnt[i]   <= 0;
                    mdl_ready[i] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) noise <= NREG'($urandom);

    always_comb begin
        reg_rdata = '0;
        for (int i = 0; i < NREG; i++) reg_rdata[i*DW +: DW] = regs_mem[i];
    end

    assign reg_ready = mdl_ready | stuck_vec | (noise & ~reg_ren);

    task automatic apply_reset();
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input int hold, input bit pend);
        int k, rc, wen_n, ren_n, resp_k, strobe_err, hold_err;
        int exp_k, exp_wen_n, exp_ren_n;
        logic [NREG-1:0] exp_sel;
        logic [DW-1:0] exp_rd, got_rd;
        logic exp_err, got_err;
        bit valid_addr;

        valid_addr = (addr < AW'(NREG));
        exp_sel    = valid_addr ? (NREG'(1) << addr) : '0;
        exp_wen_n  = 0;
        exp_ren_n  = 0;
        exp_rd     = '0;
        exp_err    = 1'b0;
        if (!valid_addr) begin
            exp_err = 1'b1;
            exp_k   = 1;
        end else if (wr) begin
            exp_wen_n = 1;
            exp_k     = 2;
        end else begin
            rc     = stuck_vec[addr] ? 2 : ((lat[addr] + 1 > 2) ? lat[addr] + 1 : 2);
            exp_rd = exp_mem[addr];
`ifdef REG_BUS_TIMEOUT_EN
            if (rc > TMO) begin
                rc      = TMO;
                exp_err = 1'b1;
                exp_rd  = '0;
            end
`endif
            exp_ren_n = rc;
            exp_k     = rc + 1;
        end

        k = 0;
        while (req_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_wait: req_ready=%b required 1", req_ready);
            apply_reset();
            return;
        end

        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        if (pend) begin
            req_write = ~wr;
            req_addr  = AW'($urandom);
            req_wdata = ~wd;
        end else begin
            req_valid = 1'b0;
        end
        if (wr && valid_addr) exp_mem[addr] = wd;

        wen_n      = 0;
        ren_n      = 0;
        resp_k     = 0;
        strobe_err = 0;
        for (int c = 1; c <= 200; c++) begin
            if (reg_wen !== '0) begin
                wen_n++;
                if (reg_wen !== exp_sel || reg_wdata !== wd) strobe_err++;
            end
            if (reg_ren !== '0) begin
                ren_n++;
                if (reg_ren !== exp_sel) strobe_err++;
            end
            if (req_ready !== 1'b0) strobe_err++;
            if (resp_valid === 1'b1) begin
                resp_k = c;
                if (reg_wdata !== wd) strobe_err++;
                break;
            end
            @(negedge clk);
        end

        total++;
        if (resp_k != exp_k) begin
            bad++;
            $display("FAIL resp_latency wr=%0d addr=%0d: got %0d cycles required %0d", wr, addr, resp_k, exp_k);
        end
        if (resp_k == 0) begin
            apply_reset();
            return;
        end
        total++;
        if (wen_n != exp_wen_n) begin
            bad++;
            $display("FAIL wen_cycles addr=%0d: got %0d required %0d", addr, wen_n, exp_wen_n);
        end
        total++;
        if (ren_n != exp_ren_n) begin
            bad++;
            $display("FAIL ren_cycles addr=%0d: got %0d required %0d", addr, ren_n, exp_ren_n);
        end
        total++;
        if (strobe_err != 0) begin
            bad++;
            $display("FAIL strobe_value addr=%0d: %0d bad cycles required 0", addr, strobe_err);
        end

        got_rd  = resp_rdata;
        got_err = resp_err;
        total++;
        if (got_rd !== exp_rd) begin
            bad++;
            $display("FAIL resp_rdata addr=%0d: got %h required %h", addr, got_rd, exp_rd);
        end
        total++;
        if (got_err !== exp_err) begin
            bad++;
            $display("FAIL resp_err addr=%0d: got %b required %b", addr, got_err, exp_err);
        end

        hold_err = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== got_rd || resp_err !== got_err ||
                req_ready !== 1'b0 || reg_wen !== '0 || reg_ren !== '0) hold_err++;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        total++;
        if (hold_err != 0) begin
            bad++;
            $display("FAIL resp_hold addr=%0d: %0d unstable cycles required 0", addr, hold_err);
        end
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL handshake addr=%0d: req_ready=%b resp_valid=%b required 1/0", addr, req_ready, resp_valid);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({req_ready, resp_valid, resp_rdata, resp_err, reg_wen, reg_ren, reg_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %b required all 0",
                     {req_ready, resp_valid, resp_rdata, resp_err, reg_wen, reg_ren, reg_wdata});
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: req_ready=%b resp_valid=%b required 1/0", req_ready, resp_valid);
        end
    endtask

    task automatic test_basic();
        run_txn(1'b1, 4'd0, 4'h1, 0, 1'b0);
        lat[0] = 1;
        run_txn(1'b0, 4'd0, 4'h0, 0, 1'b0);
    endtask

    task automatic test_bad_addr();
        run_txn(1'b0, 4'd9, 4'h3, 0, 1'b0);
        run_txn(1'b1, 4'd15, 4'hA, 1, 1'b0);
        run_txn(1'b1, 4'd8, 4'h5, 0, 1'b0);
    endtask

    task automatic test_stale_ready();
        run_txn(1'b1, 4'd3, 4'h6, 0, 1'b0);
        stuck_vec[3] = 1'b1;
        run_txn(1'b0, 4'd3, 4'h0, 0, 1'b0);
        stuck_vec[3] = 1'b0;
    endtask

    task automatic test_timeout_boundary();
        run_txn(1'b1, 4'd4, 4'hC, 0, 1'b0);
        lat[4] = 15;
        run_txn(1'b0, 4'd4, 4'h0, 0, 1'b0);
        lat[4] = 16;
        run_txn(1'b0, 4'd4, 4'h0, 0, 1'b0);
        lat[4] = 1;
    endtask

    task automatic test_dead_reg();
        lat[5] = 100000;
`ifdef REG_BUS_TIMEOUT_EN
        run_txn(1'b0, 4'd5, 4'h0, 0, 1'b0);
`else
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'd5;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (99) @(negedge clk);
        total++;
        if (reg_ren !== 8'h20 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL dead_wait: ren=%b resp_valid=%b req_ready=%b required 00100000/0/0",
                     reg_ren, resp_valid, req_ready);
        end
        apply_reset();
`endif
        lat[5] = 1;
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, 4'd7, 4'h9, 0, 1'b0);
        run_txn(1'b1, 4'd1, 4'h5, 0, 1'b0);
        lat[7] = 2;
        run_txn(1'b0, 4'd7, 4'h0, 0, 1'b0);
        lat[1] = 1;
        run_txn(1'b0, 4'd1, 4'h0, 0, 1'b0);
    endtask

    task automatic test_resp_hold();
        run_txn(1'b1, 4'd6, 4'hE, 5, 1'b1);
        lat[6] = 3;
        run_txn(1'b0, 4'd6, 4'h0, 5, 1'b1);
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int n = 0; n < 40; n++) begin
            a = AW'($urandom_range(0, 11));
            if (a < AW'(NREG)) begin
                lat[a]       = $urandom_range(1, 20);
                stuck_vec[a] = ($urandom_range(0, 5) == 0);
            end
            run_txn(1'($urandom_range(0, 1)), a, DW'($urandom), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
        end
        stuck_vec = '0;
    endtask

    task automatic test_reset_mid();
        int k;
        lat[2] = 10;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'd2;
        req_wdata = 4'h7;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (reg_ren !== 8'h04) begin
            bad++;
            $display("FAIL mid_precond: ren=%b required 00000100", reg_ren);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({req_ready, resp_valid, resp_rdata, resp_err, reg_wen, reg_ren, reg_wdata} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %b required all 0",
                     {req_ready, resp_valid, resp_rdata, resp_err, reg_wen, reg_ren, reg_wdata});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_release: req_ready=%b resp_valid=%b required 1/0", req_ready, resp_valid);
        end
        k = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || reg_ren !== '0) k++;
        end
        total++;
        if (k != 0) begin
            bad++;
            $display("FAIL stale_resp: %0d cycles with activity required 0", k);
        end
        lat[2] = 1;
        run_txn(1'b0, 4'd2, 4'h0, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            lat[i]     = 1;
            exp_mem[i] = '0;
        end
        test_reset();
        test_basic();
        test_bad_addr();
        test_stale_ready();
        test_timeout_boundary();
        test_back_to_back();
        test_resp_hold();
        test_dead_reg();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
